// File: rtl/hazard_stall_ctrl_if.sv
// rtl/hazard_stall_ctrl_if.sv - pipeline-side signal bundle for the hazard/stall controller
interface hazard_stall_ctrl_if #(
    parameter int CNT_W = 32
);
    logic [31:0]      ifid_inst_i;
    logic             idex_memread_i;
    logic [4:0]       idex_rt_i;
    logic             branch_taken_i;
    logic             dmem_req_i;
    logic             dmem_ack_i;
    logic             pc_write_o;
    logic             ifid_write_o;
    logic             ifid_flush_o;
    logic             idex_flush_o;
    logic             pipe_hold_o;
    logic             memwb_flush_o;
    logic             err_o;
    logic [CNT_W-1:0] stall_cnt_o;

    modport master (
        output ifid_inst_i, idex_memread_i, idex_rt_i, branch_taken_i, dmem_req_i, dmem_ack_i,
        input  pc_write_o, ifid_write_o, ifid_flush_o, idex_flush_o, pipe_hold_o,
               memwb_flush_o, err_o, stall_cnt_o
    );

    modport slave (
        input  ifid_inst_i, idex_memread_i, idex_rt_i, branch_taken_i, dmem_req_i, dmem_ack_i,
        output pc_write_o, ifid_write_o, ifid_flush_o, idex_flush_o, pipe_hold_o,
               memwb_flush_o, err_o, stall_cnt_o
    );
endinterface

// File: rtl/hazard_stall_ctrl.sv
// rtl/hazard_stall_ctrl.sv - load-use, branch-flush and data-memory stall control for the 5-stage core
module hazard_stall_ctrl #(
    parameter int TIMEOUT = 64,
    parameter int CNT_W   = 32
) (
    input logic              clk_i,
    input logic              rst_i,
    hazard_stall_ctrl_if.slave bus
);
    localparam int WC_W = $clog2(TIMEOUT + 1);
    localparam logic [WC_W-1:0] WC_LAST = WC_W'(TIMEOUT - 1);
    localparam logic [WC_W-1:0] WC_ONE  = WC_W'(1);

    typedef enum logic [1:0] {ST_RUN, ST_MEM_WAIT, ST_ERR} state_t;

    state_t           r_state;
    logic [WC_W-1:0]  r_wait_cnt;
    logic [CNT_W-1:0] r_stall_cnt;

    logic [4:0] w_rs;
    logic [4:0] w_rt;
    logic       w_lu;
    logic       w_mstl;
    logic       w_ack;
    logic       w_hold;
    logic       w_pc_write;
    logic       w_unused_bits;

    assign w_rs          = bus.ifid_inst_i[25:21];
    assign w_rt          = bus.ifid_inst_i[20:16];
    assign w_unused_bits = ^{bus.ifid_inst_i[31:26], bus.ifid_inst_i[15:0]};

    assign w_lu   = bus.idex_memread_i && (bus.idex_rt_i != 5'd0) &&
                    ((bus.idex_rt_i == w_rs) || (bus.idex_rt_i == w_rt));
    assign w_ack  = bus.dmem_req_i & bus.dmem_ack_i;
    assign w_mstl = bus.dmem_req_i & ~bus.dmem_ack_i;

    // An ack in MEM_WAIT releases the hold in the same cycle, so the RUN decode takes over.
    always_comb begin
        w_hold = 1'b0;
        case (r_state)
            ST_RUN:      w_hold = w_mstl;
            ST_MEM_WAIT: w_hold = ~w_ack;
            ST_ERR:      w_hold = 1'b1;
            default:     w_hold = 1'b1;
        endcase
    end

    assign w_pc_write        = ~rst_i & ~w_hold & ~w_lu;
    assign bus.pc_write_o    = w_pc_write;
    assign bus.ifid_write_o  = w_pc_write;
    assign bus.idex_flush_o  = ~rst_i & ~w_hold & w_lu;
    assign bus.ifid_flush_o  = ~rst_i & ~w_hold & ~w_lu & bus.branch_taken_i;
    assign bus.pipe_hold_o   = ~rst_i & w_hold;
    assign bus.memwb_flush_o = ~rst_i & w_hold;
    assign bus.err_o         = (r_state == ST_ERR);
    assign bus.stall_cnt_o   = r_stall_cnt;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_state    <= ST_RUN;
            r_wait_cnt <= '0;
        end else begin
            case (r_state)
                ST_RUN: begin
                    if (w_mstl) begin
                        r_state    <= ST_MEM_WAIT;
                        r_wait_cnt <= WC_ONE;
                    end
                end
                ST_MEM_WAIT: begin
                    if (w_ack) begin
                        r_state    <= ST_RUN;
                        r_wait_cnt <= '0;
                    end else if (r_wait_cnt == WC_LAST) begin
                        r_state <= ST_ERR;
                    end else begin
                        r_wait_cnt <= r_wait_cnt + WC_ONE;
                    end
                end
                ST_ERR:  r_state <= ST_ERR;
                default: r_state <= ST_ERR;
            endcase
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_stall_cnt <= '0;
        end else if (!w_pc_write && (r_stall_cnt != {CNT_W{1'b1}})) begin
            r_stall_cnt <= r_stall_cnt + CNT_W'(1);
        end
    end
endmodule

// File: tb/tb_hazard_stall_ctrl.sv
// tb/tb_hazard_stall_ctrl.sv - directed bench for hazard_stall_ctrl with TIMEOUT=4, CNT_W=4
module tb_hazard_stall_ctrl;
    logic clk_i = 1'b0;
    logic rst_i = 1'b1;
    int   tests = 0;
    int   fails = 0;

    localparam logic [31:0] ADD_R2_R4 = {6'h00, 5'd2, 5'd4, 5'd3, 5'd0, 6'h20};
    localparam logic [31:0] ADD_R0_R4 = {6'h00, 5'd0, 5'd4, 5'd3, 5'd0, 6'h20};
    localparam logic [31:0] SW_R5_R7  = {6'h2B, 5'd7, 5'd5, 16'h0000};
    localparam logic [31:0] ADD_R8_R9 = {6'h00, 5'd8, 5'd9, 5'd10, 5'd0, 6'h20};

    hazard_stall_ctrl_if #(.CNT_W(4)) bus ();

    hazard_stall_ctrl #(.TIMEOUT(4), .CNT_W(4)) dut (
        .clk_i (clk_i),
        .rst_i (rst_i),
        .bus   (bus.slave)
    );

    always #5 clk_i = ~clk_i;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic drive(input logic [31:0] inst, input logic mr, input logic [4:0] rt,
                         input logic br, input logic req, input logic ack);
        bus.ifid_inst_i    = inst;
        bus.idex_memread_i = mr;
        bus.idex_rt_i      = rt;
        bus.branch_taken_i = br;
        bus.dmem_req_i     = req;
        bus.dmem_ack_i     = ack;
        #2;
    endtask

    task automatic cyc;
        @(posedge clk_i);
        #1;
    endtask

    // packs {pc_write, ifid_write, ifid_flush, idex_flush, pipe_hold, memwb_flush, err}
    function automatic logic [6:0] ctl();
        return {bus.pc_write_o, bus.ifid_write_o, bus.ifid_flush_o, bus.idex_flush_o,
                bus.pipe_hold_o, bus.memwb_flush_o, bus.err_o};
    endfunction

    initial begin
        drive(ADD_R2_R4, 1'b1, 5'd2, 1'b1, 1'b1, 1'b0);
        chk("reset_ctl", ctl(), 7'b0000000);
        chk("reset_cnt", bus.stall_cnt_o, 4'd0);
        cyc();
        cyc();
        chk("reset_cnt_held", bus.stall_cnt_o, 4'd0);
        drive(ADD_R8_R9, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0);
        rst_i = 1'b0;
        #1;
        chk("idle_ctl", ctl(), 7'b1100000);
        cyc();
        chk("idle_cnt", bus.stall_cnt_o, 4'd0);

        drive(ADD_R2_R4, 1'b1, 5'd2, 1'b0, 1'b0, 1'b0);
        chk("lu_rs_ctl", ctl(), 7'b0001000);
        cyc();
        drive(ADD_R8_R9, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0);
        chk("after_lu_ctl", ctl(), 7'b1100000);
        chk("lu_cnt", bus.stall_cnt_o, 4'd1);
        cyc();

        drive(ADD_R0_R4, 1'b1, 5'd0, 1'b0, 1'b0, 1'b0);
        chk("lu_r0_ctl", ctl(), 7'b1100000);
        cyc();
        chk("lu_r0_cnt", bus.stall_cnt_o, 4'd1);

        drive(SW_R5_R7, 1'b1, 5'd5, 1'b0, 1'b0, 1'b0);
        chk("lu_rt_ctl", ctl(), 7'b0001000);
        cyc();
        chk("lu_rt_cnt", bus.stall_cnt_o, 4'd2);

        drive(ADD_R2_R4, 1'b1, 5'd2, 1'b1, 1'b0, 1'b0);
        chk("lu_br_ctl", ctl(), 7'b0001000);
        cyc();
        drive(ADD_R2_R4, 1'b0, 5'd2, 1'b1, 1'b0, 1'b0);
        chk("br_ctl", ctl(), 7'b1110000);
        cyc();
        chk("br_cnt", bus.stall_cnt_o, 4'd3);

        for (int i = 0; i < 3; i++) begin
            drive(ADD_R8_R9, 1'b0, 5'd0, 1'b0, 1'b1, 1'b0);
            chk($sformatf("mem_hold_%0d", i), ctl(), 7'b0000110);
            cyc();
        end
        drive(ADD_R8_R9, 1'b0, 5'd0, 1'b0, 1'b1, 1'b1);
        chk("mem_ack_ctl", ctl(), 7'b1100000);
        cyc();
        drive(ADD_R8_R9, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0);
        chk("mem_cnt", bus.stall_cnt_o, 4'd6);
        chk("mem_done_ctl", ctl(), 7'b1100000);

        drive(ADD_R8_R9, 1'b0, 5'd0, 1'b0, 1'b0, 1'b1);
        chk("stray_ack_ctl", ctl(), 7'b1100000);
        cyc();

        drive(ADD_R8_R9, 1'b0, 5'd0, 1'b0, 1'b1, 1'b0);
        cyc();
        chk("mw2_ctl", ctl(), 7'b0000110);
        rst_i = 1'b1;
        #1;
        chk("mw_rst_ctl", ctl(), 7'b0000000);
        chk("mw_rst_cnt", bus.stall_cnt_o, 4'd0);
        cyc();
        drive(ADD_R8_R9, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0);
        rst_i = 1'b0;
        #1;
        chk("post_rst_ctl", ctl(), 7'b1100000);
        cyc();
        chk("post_rst_cnt", bus.stall_cnt_o, 4'd0);

        drive(ADD_R8_R9, 1'b0, 5'd0, 1'b0, 1'b1, 1'b0);
        for (int i = 0; i < 4; i++) begin
            chk($sformatf("to_hold_%0d", i), ctl(), 7'b0000110);
            cyc();
        end
        chk("err_ctl", ctl(), 7'b0000111);
        chk("err_cnt", bus.stall_cnt_o, 4'd4);
        drive(ADD_R2_R4, 1'b1, 5'd2, 1'b1, 1'b1, 1'b1);
        chk("err_ack_ctl", ctl(), 7'b0000111);
        cyc();
        chk("err_ack_cnt", bus.stall_cnt_o, 4'd5);
        for (int i = 0; i < 20; i++) cyc();
        chk("sat_cnt", bus.stall_cnt_o, 4'd15);
        chk("sat_err", bus.err_o, 1'b1);

        rst_i = 1'b1;
        #1;
        chk("final_rst_err", bus.err_o, 1'b0);
        chk("final_rst_cnt", bus.stall_cnt_o, 4'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
